// File: rtl/qm_mem_arbiter.sv
// Round-robin arbiter giving icache (port 0) and dcache (port 1) refills one burst at a time on the RAM read port.
// Optional read watchdog: define QM_MEM_ARB_TIMEOUT_EN.
module qm_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [29:0] addr0,
  input  logic [29:0] addr1,
  input  logic [5:0]  bl0,
  input  logic [5:0]  bl1,
  output logic [31:0] rd_data,
  output logic        rd_valid0,
  output logic        rd_valid1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        mem_cmd_clk,
  output logic        mem_rd_clk,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_addr,
  input  logic        mem_cmd_full,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_empty,
  input  logic [6:0]  mem_rd_count,
  input  logic        mem_rd_full
);

  typedef enum logic [1:0] {IDLE, CMD, READ, DONE} state_t;

  state_t      r_state, w_next;
  logic        r_grant, r_last;
  logic [5:0]  r_cnt;
  logic        w_sel, w_word, w_last_word, w_tmo;
  logic        w_unused;

  assign mem_cmd_clk = clk;
  assign mem_rd_clk  = clk;
  assign w_unused    = ^{mem_rd_count, mem_rd_full, TIMEOUT_CYCLES[0]};

  // On a tie the port that did not win last time gets the grant.
  assign w_sel       = (req0 && req1) ? ~r_last : req1;
  assign w_word      = (r_state == READ) && !mem_rd_empty;
  assign w_last_word = w_word && (r_cnt == mem_cmd_bl);

`ifdef QM_MEM_ARB_TIMEOUT_EN
  logic [31:0] r_wd;
  assign w_tmo = (r_state == READ) && !w_word && (r_wd == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)                 r_wd <= '0;
    else if (r_state != READ)  r_wd <= '0;
    else if (w_word)           r_wd <= '0;
    else                       r_wd <= r_wd + 32'd1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req0 || req1)      w_next = CMD;
      CMD:     if (!mem_cmd_full)     w_next = READ;
      READ:    if (w_last_word)       w_next = DONE;
               else if (w_tmo)        w_next = IDLE;
      DONE:                           w_next = IDLE;
      default:                        w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = w_word;
    rd_data   = mem_rd_data;
    rd_valid0 = w_word && !r_grant;
    rd_valid1 = w_word &&  r_grant;
    done0     = (r_state == DONE) && !r_grant;
    done1     = (r_state == DONE) &&  r_grant;
    err0      = w_tmo && !r_grant;
    err1      = w_tmo &&  r_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= 1'b0;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      mem_cmd_en    <= 1'b0;
      mem_cmd_instr <= '0;
      mem_cmd_bl    <= '0;
      mem_cmd_addr  <= '0;
    end else begin
      r_state    <= w_next;
      mem_cmd_en <= (r_state == CMD) && !mem_cmd_full;
      case (r_state)
        IDLE: if (req0 || req1) begin
          r_grant       <= w_sel;
          r_last        <= w_sel;
          mem_cmd_addr  <= w_sel ? addr1 : addr0;
          mem_cmd_bl    <= w_sel ? bl1 : bl0;
          mem_cmd_instr <= 3'b001;
        end
        CMD:  if (!mem_cmd_full) r_cnt <= '0;
        READ: if (w_word) r_cnt <= r_cnt + 6'd1;
        default: ;
      endcase
    end
  end

endmodule
